msk_p2s: RTL

MSK_P2S -- requirements
Module: msk_p2s

---
 rtl/msk_p2s.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/msk_p2s.sv
// msk_p2s: MSK demodulator back end. Takes alternating Q/I hard decisions
// (Q first in every frame), differentially decodes them into a serial bit
// stream and packs each 32-bit frame MSB-first into a word.
//
// Ports
//   logic_clk_in     in   system clock, all registers on its rising edge
//   logic_rst_in     in   asynchronous active-high reset
//   demod_pulse_in   in   one-cycle frame-start strobe
//   demod_vaild_in   in   one-cycle symbol strobe (I/Q valid this cycle)
//   demod_i_in       in   I-branch hard decision
//   demod_q_in       in   Q-branch hard decision
//   p2s_pulse_out    out  demod_pulse_in delayed one cycle
//   p2s_vaild_out    out  one-cycle strobe, p2s_data_out valid
//   p2s_data_out     out  decoded serial bit (held between strobes)
//   p2s_data_cnt     out  bits emitted in the current frame, 0..32
//   p2s_word_out     out  last complete frame, first bit in [31]
//   p2s_word_vaild   out  one-cycle strobe, p2s_word_out just updated
//   p2s_overrun_out  out  sticky: symbol strobe seen with no open frame
//   debug_signal     out  probe bus, live strobes in [63:56], rest zero
module msk_p2s #(
  parameter int FRAME_BITS = 32
) (
  input  logic                  logic_clk_in,
  input  logic                  logic_rst_in,
  input  logic                  demod_pulse_in,
  input  logic                  demod_vaild_in,
  input  logic                  demod_i_in,
  input  logic                  demod_q_in,
  output logic                  p2s_pulse_out,
  output logic                  p2s_vaild_out,
  output logic                  p2s_data_out,
  output logic [6:0]            p2s_data_cnt,
  output logic [FRAME_BITS-1:0] p2s_word_out,
  output logic                  p2s_word_vaild,
  output logic                  p2s_overrun_out,
  output logic [63:0]           debug_signal
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic                  r_prev_b;
  logic                  r_sel;
  logic [6:0]            r_cnt;
  logic [FRAME_BITS-1:0] r_word_sr;
  logic [FRAME_BITS-1:0] r_word_out;
  logic                  r_pulse_d;
  logic                  r_data;
  logic                  r_vaild;
  logic                  r_word_vaild;
  logic                  r_overrun;

  logic                  w_dec_en;
  logic                  w_ovr_set;
  logic                  w_prev_eff;
  logic                  w_b;
  logic                  w_a;
  logic                  w_last;
  logic [6:0]            w_cnt_base;
  logic [6:0]            w_cnt_inc;
  logic [FRAME_BITS-1:0] w_sr_base;
  logic [FRAME_BITS-1:0] w_sr_shift;

  // State register
  always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
    if (logic_rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a pulse always (re)opens a frame; the last bit closes it.
  always_comb begin
    w_state_next = r_state;
    if (w_last) begin
      w_state_next = S_DONE;
    end else if (demod_pulse_in) begin
      w_state_next = S_RUN;
    end
  end

  // Decode control. A pulse arriving with a symbol decodes that symbol as
  // the first of the new frame, so the frame-start values (prev_b=1, Q
  // branch, empty count/shift register) are substituted combinationally.
  always_comb begin
    w_dec_en   = demod_vaild_in & (demod_pulse_in | (r_state == S_RUN));
    w_ovr_set  = demod_vaild_in & ~w_dec_en;
    w_prev_eff = demod_pulse_in ? 1'b1 : r_prev_b;
    w_b        = (demod_pulse_in | ~r_sel) ? demod_q_in : demod_i_in;
    w_a        = ~(w_b ^ w_prev_eff);
    w_cnt_base = demod_pulse_in ? 7'd0 : r_cnt;
    w_cnt_inc  = w_cnt_base + 7'd1;
    w_sr_base  = demod_pulse_in ? '0 : r_word_sr;
    w_sr_shift = {w_sr_base[FRAME_BITS-2:0], w_a};
    w_last     = w_dec_en & (w_cnt_inc == 7'(FRAME_BITS));
  end

  // Datapath
  always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
    if (logic_rst_in) begin
      r_prev_b     <= 1'b1;
      r_sel        <= 1'b0;
      r_cnt        <= 7'd0;
      r_word_sr    <= '0;
      r_word_out   <= '0;
      r_pulse_d    <= 1'b0;
      r_data       <= 1'b0;
      r_vaild      <= 1'b0;
      r_word_vaild <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_pulse_d    <= demod_pulse_in;
      r_vaild      <= w_dec_en;
      r_word_vaild <= w_last;
      if (w_dec_en) begin
        r_data    <= w_a;
        r_prev_b  <= w_b;
        r_sel     <= demod_pulse_in ? 1'b1 : ~r_sel;
        r_cnt     <= w_cnt_inc;
        r_word_sr <= w_sr_shift;
      end else if (demod_pulse_in) begin
        r_prev_b  <= 1'b1;
        r_sel     <= 1'b0;
        r_cnt     <= 7'd0;
        r_word_sr <= '0;
      end
      // Separate output word so the published frame stays stable while
      // the next frame is being shifted in.
      if (w_last) begin
        r_word_out <= w_sr_shift;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign p2s_pulse_out   = r_pulse_d;
  assign p2s_vaild_out   = r_vaild;
  assign p2s_data_out    = r_data;
  assign p2s_data_cnt    = r_cnt;
  assign p2s_word_out    = r_word_out;
  assign p2s_word_vaild  = r_word_vaild;
  assign p2s_overrun_out = r_overrun;

  assign debug_signal = {r_pulse_d, r_word_vaild, r_data, r_vaild,
                         w_b, demod_q_in, demod_i_in, demod_vaild_in,
                         56'd0};

endmodule
